// File: rtl/braille_stream_ctrl_if.sv
// Cell stream interface for braille_stream_ctrl.
// Valid/ready: a cell transfers on a rising clock edge where cell_valid and
// cell_ready are both high. The master holds cell_data stable while
// cell_valid is high and the cell has not yet transferred. cell_ready may be
// high without cell_valid.
interface braille_stream_ctrl_if;
   logic       cell_valid;
   logic [5:0] cell_data;
   logic       cell_ready;

   modport master (output cell_valid, output cell_data, input cell_ready);
   modport slave  (input cell_valid, input cell_data, output cell_ready);
endinterface

// File: rtl/braille_stream_ctrl.sv
// braille_stream_ctrl: buffers braille cells in a small FIFO and sequences
// them through an external combinational braille-to-ASCII translator.
// Number-sign and capital-sign prefix cells are consumed here. The space cell
// blanks the display. Every displayed character is held for HOLD_CYCLES
// cycles before the next cell is taken.
// Optional feature macro: BRL_CHAR_CNT_EN adds a saturating 16-bit count of
// display updates on output char_count.
module braille_stream_ctrl #(
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   braille_stream_ctrl_if.slave  cell_if,
   output logic [5:0]            trl_braille,
   input  logic [6:0]            trl_digit_1,
   input  logic [6:0]            trl_digit_2,
   output logic [6:0]            disp_digit_1,
   output logic [6:0]            disp_digit_2,
   output logic                  disp_valid,
   output logic                  num_mode,
   output logic                  cap_pending,
   output logic                  busy,
   output logic [1:0]            dbg_state
`ifdef BRL_CHAR_CNT_EN
   ,
   output logic [15:0]           char_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

   localparam logic [5:0] CELL_NUM   = 6'b001111;
   localparam logic [5:0] CELL_CAP   = 6'b000001;
   localparam logic [5:0] CELL_SPACE = 6'b000000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      SAMPLE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [5:0]    cur_q, cur_d;
   logic [6:0]    d1_q, d1_d;
   logic [6:0]    d2_q, d2_d;
   logic          dv_q, dv_d;
   logic          num_q, num_d;
   logic          cap_q, cap_d;

   logic [5:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic          full, empty, push, pop;

   // The extra pointer bit tells a full FIFO from an empty one when the
   // address bits match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push  = cell_if.cell_valid && !full;

   assign cell_if.cell_ready = !full;
   assign trl_braille        = cur_q;
   assign disp_digit_1       = d1_q;
   assign disp_digit_2       = d2_q;
   assign disp_valid         = dv_q;
   assign num_mode           = num_q;
   assign cap_pending        = cap_q;
   assign busy               = (state_q != IDLE);
   assign dbg_state          = state_q;

   // FIFO storage. It needs no reset because the pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= cell_if.cell_data;
      end
   end

   // FIFO pointers. A push and a pop in the same cycle are both applied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   // Sequencer next state. SAMPLE is one cycle after EVAL so the translator
   // has a full cycle to settle on the new cur_cell.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cur_d   = cur_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      dv_d    = 1'b0;
      num_d   = num_q;
      cap_d   = cap_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               cur_d   = mem_q[rd_ptr_q[AW-1:0]];
               state_d = EVAL;
            end
         end
         EVAL: begin
            case (cur_q)
               CELL_NUM: begin
                  num_d   = 1'b1;
                  state_d = IDLE;
               end
               CELL_CAP: begin
                  cap_d   = 1'b1;
                  state_d = IDLE;
               end
               CELL_SPACE: begin
                  num_d   = 1'b0;
                  cap_d   = 1'b0;
                  d1_d    = 7'b0000000;
                  d2_d    = 7'b0000000;
                  dv_d    = 1'b1;
                  state_d = HOLD;
               end
               default: state_d = SAMPLE;
            endcase
         end
         SAMPLE: begin
            d1_d    = trl_digit_1;
            d2_d    = trl_digit_2;
            dv_d    = 1'b1;
            cap_d   = 1'b0;
            state_d = HOLD;
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer, display and indicator registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cur_q   <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         dv_q    <= 1'b0;
         num_q   <= 1'b0;
         cap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cur_q   <= cur_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         dv_q    <= dv_d;
         num_q   <= num_d;
         cap_q   <= cap_d;
      end
   end

`ifdef BRL_CHAR_CNT_EN
   logic [15:0] char_cnt_q;

   assign char_count = char_cnt_q;

   // Count display updates. The count saturates at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         char_cnt_q <= '0;
      end else if (dv_d && (char_cnt_q != 16'hFFFF)) begin
         char_cnt_q <= char_cnt_q + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_braille_stream_ctrl.sv
// Directed testbench for braille_stream_ctrl. It provides a small translator
// model and checks latency, prefixes, space, backpressure ordering and reset.
module tb_braille_stream_ctrl;

   localparam int DEPTH       = 4;
   localparam int HOLD_CYCLES = 8;

   logic       clk;
   logic       rst_n;
   logic [5:0] trl_braille;
   logic [6:0] trl_digit_1, trl_digit_2;
   logic [6:0] disp_digit_1, disp_digit_2;
   logic       disp_valid, num_mode, cap_pending, busy;
   logic [1:0] dbg_state;
`ifdef BRL_CHAR_CNT_EN
   logic [15:0] char_count;
`endif

   braille_stream_ctrl_if bif ();

   braille_stream_ctrl #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD_CYCLES)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cell_if      (bif.slave),
      .trl_braille  (trl_braille),
      .trl_digit_1  (trl_digit_1),
      .trl_digit_2  (trl_digit_2),
      .disp_digit_1 (disp_digit_1),
      .disp_digit_2 (disp_digit_2),
      .disp_valid   (disp_valid),
      .num_mode     (num_mode),
      .cap_pending  (cap_pending),
      .busy         (busy),
      .dbg_state    (dbg_state)
`ifdef BRL_CHAR_CNT_EN
      ,
      .char_count   (char_count)
`endif
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Translator model: 100100 maps to "6","7". Any other cell maps to a
   // unique code pattern derived from the cell.
   function automatic logic [13:0] trl_model(input logic [5:0] c);
      if (c == 6'b100100) return {7'h36, 7'h37};
      return {1'b1, c, 1'b0, ~c};
   endfunction

   assign {trl_digit_1, trl_digit_2} = trl_model(trl_braille);

   // Scoreboard
   int n_checks = 0;
   int n_errors = 0;
   int n_disp   = 0;
   logic [6:0] got_q[$];
   logic [6:0] exp_q[$];

   // Record every display pulse and its digit_1 value.
   always @(posedge clk) begin
      if (disp_valid === 1'b1) begin
         n_disp = n_disp + 1;
         got_q.push_back(disp_digit_1);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [5:0] c);
      int g;
      bif.cell_valid = 1'b1;
      bif.cell_data  = c;
      g = 0;
      while (!bif.cell_ready && g < 200) begin
         tick();
         g++;
      end
      if (g >= 200) check("push_timeout", 0, 1);
      tick();
      bif.cell_valid = 1'b0;
   endtask

   task automatic wait_disp();
      int g;
      g = 0;
      while (disp_valid !== 1'b1 && g < 200) begin
         tick();
         g++;
      end
      if (g >= 200) check("disp_timeout", 0, 1);
   endtask

   task automatic wait_quiet();
      int g, q;
      g = 0;
      q = 0;
      while (q < 3 && g < 1000) begin
         tick();
         g++;
         if (busy === 1'b0) q++;
         else q = 0;
      end
      if (g >= 1000) check("quiet_timeout", 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   // Directed test sequence
   initial begin
      int d0, base, idx, accepts, first_drop, g;
      logic [5:0] cells [8];
      cells[0] = 6'b110000; cells[1] = 6'b101000; cells[2] = 6'b100010;
      cells[3] = 6'b011000; cells[4] = 6'b110100; cells[5] = 6'b111000;
      cells[6] = 6'b010100; cells[7] = 6'b100110;

      rst_n = 1'b0;
      bif.cell_valid = 1'b0;
      bif.cell_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", bif.cell_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_trl", trl_braille, 0);
      check("rst_disp", {disp_digit_1, disp_digit_2}, 0);
      check("rst_flags", {disp_valid, num_mode, cap_pending}, 0);
`ifdef BRL_CHAR_CNT_EN
      check("rst_char_count", char_count, 0);
`endif
      rst_n = 1'b1;
      tick();

      // The first display pulse comes three edges after the push.
      push(6'b100100);
      check("lat_trl_e0", trl_braille, 0);
      tick();
      check("lat_trl_e1", trl_braille, 6'b100100);
      check("lat_busy_e1", busy, 1);
      check("lat_dv_e1", disp_valid, 0);
      tick();
      check("lat_dv_e2", disp_valid, 0);
      tick();
      check("lat_dv_e3", disp_valid, 1);
      check("lat_d1", disp_digit_1, 7'h36);
      check("lat_d2", disp_digit_2, 7'h37);
      for (int i = 1; i < HOLD_CYCLES; i++) begin
         tick();
         check("hold_busy", busy, 1);
         check("hold_dv", disp_valid, 0);
      end
      tick();
      check("hold_exit_busy", busy, 0);
      check("hold_keep_d1", disp_digit_1, 7'h36);

      // Prefix cells
      d0 = n_disp;
      push(6'b001111);
      wait_quiet();
      check("num_set", num_mode, 1);
      check("num_no_cap", cap_pending, 0);
      check("num_no_disp", n_disp - d0, 0);
      push(6'b000001);
      wait_quiet();
      check("cap_set", cap_pending, 1);
      check("cap_num_kept", num_mode, 1);
      check("cap_no_disp", n_disp - d0, 0);
      push(6'b101110);
      wait_quiet();
      check("letter_disp", n_disp - d0, 1);
      check("letter_cap_clr", cap_pending, 0);
      check("letter_num_kept", num_mode, 1);
      check("letter_d1", disp_digit_1, {1'b1, 6'b101110});
      check("letter_d2", disp_digit_2, {1'b0, 6'b010001});

      // Space cell
      d0 = n_disp;
      push(6'b000000);
      wait_quiet();
      check("space_num_clr", num_mode, 0);
      check("space_digits", {disp_digit_1, disp_digit_2}, 0);
      check("space_disp", n_disp - d0, 1);

      // Backpressure: keep cell_valid high during the hold of a lead cell.
      base = got_q.size();
      exp_q.push_back({1'b1, 6'b110110});
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, cells[i]});
      push(6'b110110);
      wait_disp();
      idx = 0;
      accepts = 0;
      first_drop = -1;
      g = 0;
      bif.cell_valid = 1'b1;
      bif.cell_data  = cells[0];
      while (idx < 8 && g < 600) begin
         if (bif.cell_ready) begin
            tick();
            idx++;
            accepts++;
            if (idx < 8) bif.cell_data = cells[idx];
         end else begin
            if (first_drop < 0) first_drop = accepts;
            tick();
         end
         g++;
      end
      bif.cell_valid = 1'b0;
      if (g >= 600) check("bp_timeout", 0, 1);
      check("bp_first_drop", first_drop, 4);
      check("bp_accepts", accepts, 8);
      wait_quiet();
      check("bp_count", got_q.size() - base, 9);
      for (int i = 0; i < 9; i++) begin
         if (base + i < got_q.size()) check("bp_order", got_q[base + i], exp_q[0]);
         else check("bp_missing", 0, 1);
         void'(exp_q.pop_front());
      end

      // Reset in the middle of a hold, with two cells queued.
      push(6'b101010);
      wait_disp();
      push(6'b010101);
      push(6'b011011);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst_busy", busy, 0);
      check("mrst_ready", bif.cell_ready, 1);
      check("mrst_trl", trl_braille, 0);
      check("mrst_disp", {disp_digit_1, disp_digit_2}, 0);
      check("mrst_flags", {disp_valid, num_mode, cap_pending}, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      d0 = n_disp;
      repeat (20) tick();
      check("mrst_no_disp", n_disp - d0, 0);
      check("mrst_idle", busy, 0);
`ifdef BRL_CHAR_CNT_EN
      check("mrst_char_count", char_count, 0);
`endif

      // Five letters and one prefix after the reset.
      d0 = n_disp;
      push(6'b110010);
      push(6'b001111);
      push(6'b100011);
      push(6'b111100);
      push(6'b010110);
      push(6'b100001);
      wait_quiet();
      check("post_disp", n_disp - d0, 5);
      check("post_d1", disp_digit_1, {1'b1, 6'b100001});
`ifdef BRL_CHAR_CNT_EN
      check("char_count", char_count, 5);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/braille_stream_ctrl.md
Name: braille_stream_ctrl

Overview:
- Sequencer in front of the combinational braille-to-ASCII translator (6-bit cell in; two 7-bit digit codes out).
- Accepts a stream of braille cells over a valid/ready handshake and buffers them in a small FIFO.
- Consumes prefix cells (number sign, capital sign) and handles the space cell itself; forwards all other cells to the translator.
- Latches the translator's digit pair onto a display register and holds it for a programmable number of cycles before the next cell.

Parameters:
- DEPTH, 4, FIFO depth in cells; power of two, >= 2.
- HOLD_CYCLES, 8, cycles each displayed character is held; >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cell_valid  input  1  upstream cell valid.
- cell_data  input  6  braille cell, dot1 at MSB.
- cell_ready  output  1  FIFO can accept a cell (= not full).
- trl_braille  output  6  cell driven to the translator.
- trl_digit_1  input  7  translator digit_1.
- trl_digit_2  input  7  translator digit_2.
- disp_digit_1  output  7  latched display digit 1.
- disp_digit_2  output  7  latched display digit 2.
- disp_valid  output  1  one-cycle pulse when the display registers update.
- num_mode  output  1  number indicator active.
- cap_pending  output  1  capital indicator pending for the next letter.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0) clears the following immediately:
  - FIFO pointers, so the FIFO is empty.
  - State to IDLE; hold counter to 0.
  - cur_cell, trl_braille, disp_digit_1 and disp_digit_2 to 0.
  - disp_valid, num_mode and cap_pending to 0.
  - A reset mid-operation discards all buffered cells and any in-progress hold.
- Handshake and FIFO:
  - A push occurs when cell_valid && cell_ready; cell_ready = !full.
  - A push and a pop in the same cycle are both honoured.
  - Pointers wrap modulo DEPTH. The full/empty distinction uses one extra pointer bit.
- trl_braille is driven continuously from the cur_cell register.
- FSM:
  - IDLE: if the FIFO is not empty, pop the head into cur_cell and go to EVAL. Otherwise stay in IDLE.
  - EVAL: classify cur_cell.
    - 001111 (number sign): set num_mode, go to IDLE; no display update.
    - 000001 (capital sign): set cap_pending, go to IDLE; no display update.
    - 000000 (space): clear num_mode and cap_pending; load both display digits with 7'b0000000; pulse disp_valid; go to HOLD.
    - Any other cell: go to SAMPLE. This gives the combinational translator one full cycle to settle.
  - SAMPLE: latch trl_digit_1/2 into disp_digit_1/2, pulse disp_valid, clear cap_pending, go to HOLD.
  - HOLD: increment the counter. When counter == HOLD_CYCLES-1, clear the counter and go to IDLE.
- Latency:
  - For a letter pushed at edge E0 into an empty FIFO with state IDLE, disp_valid is high in the cycle after edge E3.
  - The next cell is popped at the first edge after HOLD exits.
- Prefix cells take 2 cycles (IDLE→EVAL→IDLE).
- Display registers are unchanged outside SAMPLE and space-EVAL.

Optional Feature:
- Macro: BRL_CHAR_CNT_EN.
- When defined:
  - Adds output char_count[15:0], reset to 0.
  - It increments on every disp_valid pulse and saturates at 16'hFFFF.
- When undefined:
  - The port and its counter are absent.
  - All other behaviour is identical.

Test Plan:
- Letter latency:
  - Stimulus: reset, then push 100100; translator model returns the 7-bit codes for "6","7".
  - Response: trl_braille=100100 from the edge after the push. disp_digit_1/2 equal the model codes and disp_valid=1 for exactly one cycle, 3 edges after the push. busy stays high HOLD_CYCLES cycles after SAMPLE.
- Prefix handling:
  - Stimulus: push 001111, then 000001, then 101110.
  - Response: num_mode=1 and cap_pending=1 with no disp_valid for the prefixes. One disp_valid for 101110, after which cap_pending=0 and num_mode stays 1.
- Space:
  - Stimulus: with num_mode=1, push 000000.
  - Response: num_mode=0, disp digits = 0, one disp_valid pulse.
- Backpressure with DEPTH=4:
  - Stimulus: hold cell_valid=1 during HOLD with 8 distinct cells.
  - Response: cell_ready drops after 4 accepts, the FIFO never overflows, and all 8 cells are displayed in order.
- Mid-hold reset:
  - Stimulus: assert rst_n=0 asynchronously mid-HOLD with 2 cells queued.
  - Response: all outputs 0 immediately and cell_ready=1. After release, no display update until a new push.
- BRL_CHAR_CNT_EN:
  - Stimulus: push 5 letters and 1 prefix.
  - Response: char_count=5.
